// File: rtl/rsp_s1_prep_ahb_cfg_master_pkg.sv
// Shared AHB-Lite encodings, FSM state and requester id types for the
// S1 prep AHB configuration master.
package rsp_s1_prep_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_BADCH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rsp_s1_prep_ahb_cfg_master_if.sv
// AHB-Lite bus bundle between the configuration master and the S1 prep
// channel mux slave port.
interface rsp_s1_prep_ahb_cfg_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          hsel;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hreadyin;
  logic [DW-1:0] hrdata;
  logic [1:0]    hresp;
  logic          hready;

  modport master (
    output hsel, htrans, haddr, hburst, hsize, hwrite, hwdata, hreadyin,
    input  hrdata, hresp, hready
  );

  modport slave (
    input  hsel, htrans, haddr, hburst, hsize, hwrite, hwdata, hreadyin,
    output hrdata, hresp, hready
  );
endinterface

// File: rtl/rsp_s1_prep_ahb_cfg_master_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the side that wins a
// tie; after every grant it moves to the side that did not win.
module rsp_s1_prep_rr_arb2
  import rsp_s1_prep_ahb_pkg::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t ptr_q;

  // Grants are combinational and only offered while the master can accept.
  always_comb begin
    gnt_a = en && req_a && (!req_b || (ptr_q == REQ_A));
    gnt_b = en && req_b && (!req_a || (ptr_q == REQ_B));
  end

  // Pointer advances away from the winner on every handshake.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ptr_q <= REQ_A;
    end else if (gnt_a) begin
      ptr_q <= other_req(REQ_A);
    end else if (gnt_b) begin
      ptr_q <= other_req(REQ_B);
    end
  end

endmodule

// File: rtl/rsp_s1_prep_ahb_cfg_master.sv
// AHB-Lite single-master configuration controller for the S1 prep channel
// mux. Two requesters (A: host bridge, B: auto-loader) are arbitrated
// round-robin; each command becomes one SINGLE/NONSEQ word transfer.
//
// Requester handshake: a command transfers on a cycle where req_x_valid
// and req_x_ready are both high. ready is combinational, only offered in
// IDLE and only to the arbitration winner. A requester holding valid
// without ready keeps its command fields stable. rsp_x_valid is a
// one-cycle pulse with no back-pressure.
//
// Optional build macro RSP_S1_PREP_CFG_TIMEOUT_EN adds a wait-state
// watchdog (TO_CYCLES) with an error response and a DRAIN recovery state.
module rsp_s1_prep_ahb_cfg_master
  import rsp_s1_prep_ahb_pkg::*;
#(
  parameter int                N_CH      = 7,
  parameter int                AHB_DW    = 32,
  parameter int                AHB_AW    = 32,
  parameter logic [AHB_AW-1:0] CH_BASE   = '0,
  parameter int                CH_LOG2   = 10,
  parameter int                TO_CYCLES = 256
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic [2:0]        req_a_ch,
  input  logic [9:0]        req_a_ofs,
  input  logic              req_a_write,
  input  logic [AHB_DW-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [AHB_DW-1:0] rsp_a_rdata,
  output logic              rsp_a_err,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic [2:0]        req_b_ch,
  input  logic [9:0]        req_b_ofs,
  input  logic              req_b_write,
  input  logic [AHB_DW-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [AHB_DW-1:0] rsp_b_rdata,
  output logic              rsp_b_err,
  output logic              busy,
  output state_t            dbg_state,
  rsp_s1_prep_ahb_cfg_master_if.master bus
);

  state_t            state_q, state_d;
  req_id_t           owner_q;
  logic [2:0]        cmd_ch_q;
  logic [7:0]        cmd_wofs_q;
  logic              cmd_write_q;
  logic [AHB_DW-1:0] cmd_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [AHB_DW-1:0] rsp_rdata_q;

  logic              arb_en, gnt_a, gnt_b, accept;
  logic [2:0]        acc_ch;
  logic [7:0]        acc_wofs;
  logic              acc_write;
  logic [AHB_DW-1:0] acc_wdata;
  logic              acc_bad;
  logic [AHB_AW-1:0] cmd_addr;
  logic              timeout;
  logic              drain_addr;
  logic              unused_bits;

  assign arb_en      = (state_q == ST_IDLE);
  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;
  assign accept      = gnt_a || gnt_b;
  assign dbg_state   = state_q;
  assign unused_bits = ^{req_a_ofs[1:0], req_b_ofs[1:0], bus.hresp[1]};

  rsp_s1_prep_rr_arb2 u_arb (
    .hclk    (hclk),
    .hresetn (hresetn),
    .en      (arb_en),
    .req_a   (req_a_valid),
    .req_b   (req_b_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  // Select the winning requester's command; byte lanes of the offset are dropped.
  always_comb begin
    if (gnt_b) begin
      acc_ch    = req_b_ch;
      acc_wofs  = req_b_ofs[9:2];
      acc_write = req_b_write;
      acc_wdata = req_b_wdata;
    end else begin
      acc_ch    = req_a_ch;
      acc_wofs  = req_a_ofs[9:2];
      acc_write = req_a_write;
      acc_wdata = req_a_wdata;
    end
  end

  assign acc_bad  = (int'(acc_ch) >= N_CH);
  assign cmd_addr = CH_BASE + (AHB_AW'(cmd_ch_q) << CH_LOG2) + AHB_AW'({cmd_wofs_q, 2'b00});

`ifdef RSP_S1_PREP_CFG_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            drain_addr_q;
  logic            waiting;

  assign waiting    = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !bus.hready;
  assign timeout    = waiting && (int'(to_cnt_q) == TO_CYCLES - 1);
  assign drain_addr = drain_addr_q;

  // Count consecutive wait cycles of the live transfer; any progress clears it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      to_cnt_q <= '0;
    end else if (waiting && !timeout) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end

  // Remember whether the abandoned transfer still owes its address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      drain_addr_q <= 1'b0;
    end else if (timeout) begin
      drain_addr_q <= (state_q == ST_ADDR);
    end else if ((state_q == ST_DRAIN) && bus.hready) begin
      drain_addr_q <= 1'b0;
    end
  end
`else
  logic unused_to_cycles;

  assign timeout          = 1'b0;
  assign drain_addr       = 1'b0;
  assign unused_to_cycles = ^TO_CYCLES;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = acc_bad ? ST_BADCH : ST_ADDR;
        end
      end
      ST_BADCH: state_d = ST_IDLE;
      ST_ADDR: begin
        if (timeout) begin
          state_d = ST_DRAIN;
        end else if (bus.hready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          state_d = ST_DRAIN;
        end else if (bus.hready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!drain_addr && bus.hready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AHB and status outputs decoded from the current state.
  always_comb begin
    bus.hsel     = 1'b0;
    bus.htrans   = HTRANS_IDLE;
    bus.haddr    = '0;
    bus.hwrite   = 1'b0;
    bus.hwdata   = '0;
    bus.hburst   = HBURST_SINGLE;
    bus.hsize    = HSIZE_WORD;
    bus.hreadyin = bus.hready;
    busy         = (state_q != ST_IDLE);
    if ((state_q == ST_ADDR) || ((state_q == ST_DRAIN) && drain_addr)) begin
      bus.hsel   = 1'b1;
      bus.htrans = HTRANS_NONSEQ;
      bus.haddr  = cmd_addr;
      bus.hwrite = cmd_write_q;
    end
    if ((state_q == ST_DATA) || ((state_q == ST_DRAIN) && !drain_addr)) begin
      bus.hwdata = cmd_wdata_q;
    end
  end

  // Capture the accepted command and who owns it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      owner_q     <= REQ_A;
      cmd_ch_q    <= '0;
      cmd_wofs_q  <= '0;
      cmd_write_q <= 1'b0;
      cmd_wdata_q <= '0;
    end else if (accept) begin
      owner_q     <= gnt_b ? REQ_B : REQ_A;
      cmd_ch_q    <= acc_ch;
      cmd_wofs_q  <= acc_wofs;
      cmd_write_q <= acc_write;
      cmd_wdata_q <= acc_wdata;
    end
  end

  // Build the one-cycle response pulse for the owner of the command.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept && acc_bad) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end else if (timeout) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end else if ((state_q == ST_DATA) && bus.hready) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= bus.hresp[0];
        rsp_rdata_q <= cmd_write_q ? '0 : bus.hrdata;
      end
    end
  end

  // Route the response to its owner only.
  always_comb begin
    rsp_a_valid = rsp_valid_q && (owner_q == REQ_A);
    rsp_b_valid = rsp_valid_q && (owner_q == REQ_B);
    rsp_a_err   = rsp_a_valid && rsp_err_q;
    rsp_b_err   = rsp_b_valid && rsp_err_q;
    rsp_a_rdata = rsp_a_valid ? rsp_rdata_q : '0;
    rsp_b_rdata = rsp_b_valid ? rsp_rdata_q : '0;
  end

endmodule

// File: doc/rsp_s1_prep_ahb_cfg_master.md
Name: rsp_s1_prep_ahb_cfg_master

Overview:
- AHB-Lite single-master controller that drives the slave port of the S1 prep AHB channel mux (7 channels, 1 KB window per channel, address masked to 10 bits downstream).
- Arbitrates two configuration requesters round-robin:
  - A: host register bridge.
  - B: auto-loader.
- Converts each (channel, offset, read/write) command into one SINGLE/NONSEQ word transfer and returns read data and error status to the winning requester.

Parameters:
- N_CH, 7, number of downstream channels; commands with ch >= N_CH are rejected.
- AHB_DW, 32, AHB data width.
- AHB_AW, 32, AHB address width.
- CH_BASE, 32'h0000_0000, address of channel 0 window.
- CH_LOG2, 10, log2 of per-channel window stride (haddr = CH_BASE + (ch << CH_LOG2) + {ofs[9:2],2'b00}).
- TO_CYCLES, 256, wait-state timeout limit (used only with the optional feature).

Ports:
- hclk, in, 1, clock.
- hresetn, in, 1, asynchronous active-low reset.
- req_a_valid, in, 1, requester A command valid.
- req_a_ready, out, 1, A command accepted this cycle.
- req_a_ch, in, 3, target channel.
- req_a_ofs, in, 10, byte offset in the channel window.
- req_a_write, in, 1, 1 = write, 0 = read.
- req_a_wdata, in, AHB_DW, write data.
- rsp_a_valid, out, 1, one-cycle response pulse.
- rsp_a_rdata, out, AHB_DW, read data (0 for writes and errors).
- rsp_a_err, out, 1, error response, bad channel, or timeout.
- req_b_*, rsp_b_*: same set for requester B.
- busy, out, 1, high in every non-IDLE state.
- hsel, out, 1, AHB select.
- htrans, out, 2, AHB transfer type.
- haddr, out, AHB_AW, AHB address.
- hburst, out, 3, constant 3'b000.
- hsize, out, 3, constant 3'b010.
- hwrite, out, 1, AHB write.
- hwdata, out, AHB_DW, AHB write data.
- hreadyin, out, 1, equals hready (single master).
- hrdata, in, AHB_DW, AHB read data.
- hresp, in, 2, AHB response.
- hready, in, 1, AHB ready.

Behaviour:
- Reset values:
  - hsel=0, htrans=2'b00, haddr=0, hwrite=0, hwdata=0.
  - req_*_ready=0, rsp_*_valid=0, rsp_*_rdata=0, rsp_*_err=0, busy=0.
  - Round-robin priority pointer = A.
- States:
  - IDLE: accept a command.
  - ADDR: address phase.
  - DATA: data phase.
  - BADCH: reject cycle for invalid channel.
  - DRAIN: optional timeout recovery.
- IDLE:
  - req_x_ready is combinational and high only for the arbitration winner.
  - Both requesters valid: the pointer side wins and the pointer flips to the other side.
  - Single requester valid: it wins; the pointer flips away from the winner.
  - On handshake, the command is registered.
  - Next state: ADDR, or BADCH if ch >= N_CH.
- BADCH: the next cycle pulses rsp_x_valid with err=1 and rdata=0, then goes to IDLE. No AHB activity.
- ADDR:
  - Drives hsel=1, htrans=NONSEQ, haddr, hwrite.
  - These are held stable while hready=0.
  - On hready=1, goes to DATA.
- DATA:
  - Drives hsel=0, htrans=IDLE, hwdata=registered wdata.
  - On hready=1: go to IDLE; the following cycle pulses rsp_x_valid with rdata = read ? hrdata : 0 and err = hresp[0].
  - First ERROR cycle (hready=0, hresp=ERROR) only waits.
- Latency and throughput:
  - Zero wait states: accept at cycle 0, ADDR at 1, DATA at 2, rsp_valid at 3.
  - A new accept is allowed in the same cycle as rsp_valid, giving one transaction per 3 cycles.
- The response is routed only to the granted requester. rsp_valid is never asserted for both requesters.
- The requester holding valid while not ready must keep its command stable.
- Async reset mid-transfer: everything returns to reset values immediately; no response is issued for the aborted command.
- ofs[1:0] is ignored. Offset wrap is not possible (10 bits equals the window size).

Optional Feature:
- Macro: RSP_S1_PREP_CFG_TIMEOUT_EN.
- With the macro:
  - A counter counts consecutive hready=0 cycles in ADDR or DATA.
  - On reaching TO_CYCLES: pulse rsp_x_valid with err=1 and rdata=0, then enter DRAIN.
  - DRAIN keeps AHB-legal signalling: holds the address phase until hready, runs the data phase, discards the result, then returns to IDLE.
  - busy stays high throughout DRAIN.
- Without the macro: no counter, TO_CYCLES unused, waits indefinitely, DRAIN unreachable.

Decomposition:
- Package rsp_s1_prep_ahb_pkg:
  - HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, HRESP_OKAY/ERROR.
  - State enum.
  - Requester id enum.
- Sub-module rsp_s1_prep_rr_arb2: 2-input round-robin arbiter with pointer register, advanced on handshake.

Test Plan:
- A write ch=3 ofs=0x010 wdata=0xA5A5_0001, zero waits -> haddr=0x0000_0C10, NONSEQ for 1 cycle, hwdata=0xA5A5_0001 in the data phase, rsp_a_valid at cycle 3, err=0.
- B read ch=6 ofs=0x3FC, slave inserts 2 wait states returning 0x1234_5678 -> haddr=0x0000_1BFC held for 3 cycles, rsp_b_rdata=0x1234_5678, err=0.
- A and B valid together for 4 commands each -> grants alternate A,B,A,B,...; never two responses in one cycle.
- A read ch=7 -> no hsel pulse, rsp_a_valid with err=1, rdata=0, one cycle after accept.
- Slave two-cycle ERROR on a write -> rsp_a_err=1; next command proceeds normally.
- Macro on, TO_CYCLES=8, hready held 0 for 20 cycles -> err response after 8 wait cycles, busy stays high until hready returns; hresetn pulled low mid-DATA -> all outputs at reset values asynchronously, no response.
